mem_wb_skid: RTL and testbench
==============================

// Module: mem_wb_skid
// PURPOSE
//  Memory->Writeback pipeline boundary. Captures the ALU/FPU result (muxpal_result) and the load data (ReadData) from the
//  execute/memory stage, plus destination and write controls. Selects the writeback value and presents it to the
//  integer and FP register files with a valid/ready handshake. Uses a 2-entry skid buffer so in_ready is a registered signal.
//  Also exports forwarding data for the execute stage and a writeback-stall counter.
// PARAMETERS
//  XLEN   32  datapath width
//  REGW   5   register index width
//  CNT_W  32  stall counter width
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  reset        in   1     synchronous, active-high reset
//  flush        in   1     discard all held entries (trap/redirect)
//  in_valid     in   1     upstream entry valid
//  in_ready     out  1     registered; high when the skid entry is empty
//  in_result    in   XLEN  ALU/FPU result (muxpal_result)
//  in_rdata     in   XLEN  load data (ReadData)
//  in_pc4       in   XLEN  PC+4 for JAL/JALR
//  in_rd        in   REGW  destination register
//  in_reg_wr    in   1     integer register file write
//  in_freg_wr   in   1     FP register file write
//  in_res_src   in   2     00 result, 01 rdata, 10 pc4, 11 reserved
//  out_valid    out  1     head entry valid
//  out_ready    in   1     writeback accepts head
//  wb_data      out  XLEN  selected writeback value
//  wb_rd        out  REGW  head destination
//  wb_reg_wr    out  1     out_valid & reg_wr & (rd!=0)
//  wb_freg_wr   out  1     out_valid & freg_wr (f0 is writable)
//  fwd_data     out  XLEN  equals wb_data
//  fwd_rd       out  REGW  equals wb_rd
//  stall_cnt    out  CNT_W count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Storage: head (H) and skid (S) entries, each with a valid bit and the full payload.
//  - Reset: H/S valid=0, payloads=0, in_ready=1, stall_cnt=0. All wb_* outputs are 0.
//  - accept = in_valid & in_ready.
//  - pop = out_valid & out_ready.
//  - Update rules, in priority order:
//    - flush: H.v=S.v=0 and in_ready=1. Same-cycle accept and pop are dropped. stall_cnt is not cleared.
//    - pop & S.v: H<=S. If accept, S<=input, else S.v=0.
//    - pop & !S.v: if accept, H<=input, else H.v=0.
//    - !pop & !H.v & accept: H<=input.
//    - !pop & H.v & accept: S<=input. in_ready deasserts from the next cycle.
//  - in_ready = !S.v, taken from the registered S.v.
//  - Latency: input to out_valid is 1 cycle. Throughput is 1 entry/cycle when out_ready is held high.
//  - Ordering: strict FIFO. A full buffer (H.v & S.v) never overwrites an entry.
//  - wb_data is combinational from H only. res_src=11 yields 0; flagged by an assertion in simulation.
//  - An entry with both reg_wr and freg_wr set is illegal. Both write enables drive as stored; the bench asserts this never occurs.
//  - stall_cnt wraps modulo 2^CNT_W. It is not incremented when out_valid=0.
// STRUCTURE
//  - Shared package: XLEN and REGW constants, and RES_ALU/RES_MEM/RES_PC4 encodings of res_src. The decoder uses the same encodings.
//  - One sub-module: wb_result_mux (combinational 3:1 select on res_src). It is reused by the hazard unit.
//  - The top level holds the skid control, entry registers, write-enable gating and counter.
// TESTING
//  1. Reset: hold reset 2 cycles -> in_ready=1, out_valid=0, stall_cnt=0, wb_reg_wr=0.
//  2. Streaming: 8 back-to-back entries with res_src=00, result=i*4, out_ready=1 -> wb_data 0,4,..,28 in order.
//     First output 1 cycle after the first accept. in_ready stays 1.
//  3. Backpressure: out_ready=0 with 3 offered entries -> 2 accepted, in_ready=0 from cycle 2, third held upstream.
//     Raise out_ready -> order A,B,C preserved. stall_cnt equals the number of stalled cycles.
//  4. Select/gating: rd=0 with reg_wr=1 -> wb_reg_wr=0. freg_wr=1 with rd=0 -> wb_freg_wr=1.
//     res_src=01, rdata=0xDEADBEEF -> wb_data=0xDEADBEEF. res_src=10, pc4=0x104 -> wb_data=0x104.
//  5. Flush: buffer full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear.
//  6. Reset mid-stream: reset during a stall -> all valids 0 next cycle, stall_cnt=0. No stale entry emerges after reset.

Source files
------------

// File: rtl/mem_wb_skid_pkg.sv
// mem_wb_skid_pkg: shared widths and writeback-source encodings for the MEM/WB boundary
package mem_wb_skid_pkg;
  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int CNT_W = 32;
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } res_src_e;
  function automatic logic res_src_legal(res_src_e s);
    return s != RES_RSV;
  endfunction
endpackage

// File: rtl/wb_result_mux.sv
// wb_result_mux: 3:1 writeback value select on res_src, reserved code yields zero
module wb_result_mux
  import mem_wb_skid_pkg::*;
#(
  parameter int W = 32
) (
  input  res_src_e     sel_i,
  input  logic [W-1:0] result_i,
  input  logic [W-1:0] rdata_i,
  input  logic [W-1:0] pc4_i,
  output logic [W-1:0] data_o
);
  // select ALU/FPU result, load data or link address
  always_comb
    data_o = sel_i == RES_ALU ? result_i :
             sel_i == RES_MEM ? rdata_i  :
             sel_i == RES_PC4 ? pc4_i    : '0;
endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM->WB boundary with 2-entry skid buffer, writeback select, forwarding and stall counter
module mem_wb_skid #(
  parameter int XLEN  = mem_wb_skid_pkg::XLEN,
  parameter int REGW  = mem_wb_skid_pkg::REGW,
  parameter int CNT_W = mem_wb_skid_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_result,
  input  logic [XLEN-1:0]  in_rdata,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_reg_wr,
  input  logic             in_freg_wr,
  input  logic [1:0]       in_res_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [REGW-1:0]  wb_rd,
  output logic             wb_reg_wr,
  output logic             wb_freg_wr,
  output logic [XLEN-1:0]  fwd_data,
  output logic [REGW-1:0]  fwd_rd,
  output logic [CNT_W-1:0] stall_cnt
);
  import mem_wb_skid_pkg::*;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
    logic [REGW-1:0] rd;
    logic            reg_wr;
    logic            freg_wr;
    res_src_e        res_src;
  } ent_t;
  ent_t h_q, h_d, s_q, s_d, in_e;
  logic h_v_q, h_v_d, s_v_q, s_v_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic accept, pop;
  assign in_e     = '{result: in_result, rdata: in_rdata, pc4: in_pc4, rd: in_rd,
                      reg_wr: in_reg_wr, freg_wr: in_freg_wr, res_src: res_src_e'(in_res_src)};
  assign in_ready = ~s_v_q;
  assign accept   = in_valid & in_ready;
  assign pop      = h_v_q & out_ready;
  // next-state of head/skid entries: flush wins, then pop-driven shift, then fill empty slot
  always_comb begin
    h_d   = h_q;
    s_d   = s_q;
    h_v_d = h_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      h_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (pop) begin
      h_d   = s_v_q ? s_q : accept ? in_e : h_q;
      h_v_d = s_v_q | accept;
      s_d   = s_v_q & accept ? in_e : s_q;
      s_v_d = s_v_q & accept;
    end else if (accept & ~h_v_q) begin
      h_d   = in_e;
      h_v_d = 1'b1;
    end else if (accept) begin
      s_d   = in_e;
      s_v_d = 1'b1;
    end
    stall_d = stall_q + CNT_W'(h_v_q & ~out_ready);
  end
  // entry, valid and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      s_q     <= '0;
      h_v_q   <= 1'b0;
      s_v_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      h_q     <= h_d;
      s_q     <= s_d;
      h_v_q   <= h_v_d;
      s_v_q   <= s_v_d;
      stall_q <= stall_d;
    end
  end
  wb_result_mux #(.W(XLEN)) u_mux (
    .sel_i   (h_q.res_src),
    .result_i(h_q.result),
    .rdata_i (h_q.rdata),
    .pc4_i   (h_q.pc4),
    .data_o  (wb_data)
  );
  assign out_valid  = h_v_q;
  assign wb_rd      = h_q.rd;
  assign wb_reg_wr  = h_v_q & h_q.reg_wr & (|h_q.rd);
  assign wb_freg_wr = h_v_q & h_q.freg_wr;
  assign fwd_data   = wb_data;
  assign fwd_rd     = h_q.rd;
  assign stall_cnt  = stall_q;
  a_res_src: assert property (@(posedge clk) disable iff (reset) h_v_q |-> res_src_legal(h_q.res_src));
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: directed and random stimulus against a queue-based model of the MEM/WB skid buffer
module tb_mem_wb_skid;
  typedef struct {
    logic [31:0] res;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic        fw;
    logic [1:0]  src;
  } ent_t;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_reg_wr, in_freg_wr, out_valid, out_ready;
  logic [31:0] in_result, in_rdata, in_pc4, wb_data, fwd_data, stall_cnt;
  logic [4:0]  in_rd, wb_rd, fwd_rd;
  logic [1:0]  in_res_src;
  logic        wb_reg_wr, wb_freg_wr;
  ent_t        q[$];
  ent_t        cur;
  int unsigned stall_m;
  int          checks = 0;
  int          failures = 0;
  bit          acc;
  mem_wb_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rdata(in_rdata), .in_pc4(in_pc4), .in_rd(in_rd),
    .in_reg_wr(in_reg_wr), .in_freg_wr(in_freg_wr), .in_res_src(in_res_src),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_wr(wb_reg_wr), .wb_freg_wr(wb_freg_wr), .fwd_data(fwd_data), .fwd_rd(fwd_rd),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction
  function automatic ent_t mk(logic [31:0] res, logic [31:0] rdat, logic [31:0] pc4,
                              logic [4:0] rd, logic rw, logic fw, logic [1:0] src);
    ent_t e;
    e = '{res: res, rdat: rdat, pc4: pc4, rd: rd, rw: rw, fw: fw, src: src};
    return e;
  endfunction
  function automatic ent_t rnd();
    int w;
    w = $urandom_range(0, 2);
    return mk($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), w == 1, w == 2,
              2'($urandom_range(0, 2)));
  endfunction
  task automatic drive(bit v, ent_t e);
    cur        = e;
    in_valid   = v;
    in_result  = e.res;
    in_rdata   = e.rdat;
    in_pc4     = e.pc4;
    in_rd      = e.rd;
    in_reg_wr  = e.rw;
    in_freg_wr = e.fw;
    in_res_src = e.src;
  endtask
  // check outputs against the model, advance one clock, then apply the model's update
  task automatic step(output bit a);
    bit   ir, ov, pop;
    ent_t h;
    ir = q.size() < 2;
    ov = q.size() > 0;
    chk("in_ready", 32'(in_ready), 32'(ir));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("stall_cnt", stall_cnt, stall_m);
    if (ov) begin
      h = q[0];
      chk("wb_data", wb_data, h.src == 2'd1 ? h.rdat : h.src == 2'd2 ? h.pc4 : h.res);
      chk("fwd_data", fwd_data, h.src == 2'd1 ? h.rdat : h.src == 2'd2 ? h.pc4 : h.res);
      chk("wb_rd", 32'(wb_rd), 32'(h.rd));
      chk("fwd_rd", 32'(fwd_rd), 32'(h.rd));
      chk("wb_reg_wr", 32'(wb_reg_wr), 32'(h.rw && h.rd != 0));
      chk("wb_freg_wr", 32'(wb_freg_wr), 32'(h.fw));
      chk("wr_exclusive", 32'(wb_reg_wr & wb_freg_wr), 32'd0);
    end else begin
      chk("wb_reg_wr_idle", 32'(wb_reg_wr), 32'd0);
      chk("wb_freg_wr_idle", 32'(wb_freg_wr), 32'd0);
    end
    a   = in_valid && ir;
    pop = ov && out_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      stall_m = 0;
      a = 1'b0;
    end else begin
      if (ov && !out_ready) stall_m++;
      if (flush) begin
        q.delete();
        a = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (a) q.push_back(cur);
      end
    end
  endtask
  // offer one entry until it is accepted, bounded
  task automatic send(ent_t e);
    bit a;
    a = 1'b0;
    drive(1'b1, e);
    for (int k = 0; k < 20 && !a; k++) step(a);
    if (!a) chk("accept_timeout", 32'd0, 32'd1);
    drive(1'b0, e);
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stall_m = 0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'(i * 4), 32'hFFFF_0000, 32'h1000, 5'(i + 1), 1'b1, 1'b0, 2'd0));
      step(acc);
      chk("stream_accept", 32'(acc), 32'd1);
      if (i > 0) chk("stream_data", wb_data, 32'(i * 4));
    end
    drive(1'b0, cur);
    repeat (2) step(acc);
    // backpressure
    out_ready = 1'b0;
    drive(1'b1, mk(32'hA, 0, 0, 5'd3, 1'b1, 1'b0, 2'd0));
    step(acc);
    drive(1'b1, mk(32'hB, 0, 0, 5'd4, 1'b1, 1'b0, 2'd0));
    step(acc);
    drive(1'b1, mk(32'hC, 0, 0, 5'd5, 1'b1, 1'b0, 2'd0));
    step(acc);
    chk("bp_c_held", 32'(acc), 32'd0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(acc);
    chk("bp_stall_cnt", stall_cnt, 32'd3);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) step(acc);
    if (!acc) chk("bp_accept_timeout", 32'd0, 32'd1);
    drive(1'b0, cur);
    repeat (3) step(acc);
    // select and gating
    send(mk(32'h11, 0, 0, 5'd0, 1'b1, 1'b0, 2'd0));
    chk("g_rd0_reg_wr", 32'(wb_reg_wr), 32'd0);
    send(mk(32'h22, 0, 0, 5'd0, 1'b0, 1'b1, 2'd0));
    chk("g_f0_freg_wr", 32'(wb_freg_wr), 32'd1);
    send(mk(32'h33, 32'hDEAD_BEEF, 0, 5'd7, 1'b1, 1'b0, 2'd1));
    chk("g_rdata", wb_data, 32'hDEAD_BEEF);
    send(mk(32'h44, 0, 32'h104, 5'd1, 1'b1, 1'b0, 2'd2));
    chk("g_pc4", wb_data, 32'h104);
    step(acc);
    // flush with a full buffer
    out_ready = 1'b0;
    send(mk(32'h55, 0, 0, 5'd8, 1'b1, 1'b0, 2'd0));
    send(mk(32'h66, 0, 0, 5'd9, 1'b1, 1'b0, 2'd0));
    drive(1'b1, mk(32'h77, 0, 0, 5'd10, 1'b1, 1'b0, 2'd0));
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    drive(1'b0, cur);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) step(acc);
    // reset during a stall
    out_ready = 1'b0;
    send(mk(32'h88, 0, 0, 5'd11, 1'b1, 1'b0, 2'd0));
    send(mk(32'h99, 0, 0, 5'd12, 1'b1, 1'b0, 2'd0));
    repeat (2) step(acc);
    reset = 1'b1;
    step(acc);
    reset = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_stall_cnt", stall_cnt, 32'd0);
    out_ready = 1'b1;
    repeat (3) step(acc);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rnd());
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 40) == 0;
      step(acc);
    end
    flush = 1'b0;
    drive(1'b0, cur);
    out_ready = 1'b1;
    repeat (3) step(acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
